// File: rtl/bit_serial_add_ctrl.sv
// bit_serial_add_ctrl
//   Shares one 1-bit full-adder cell across a WIDTH-bit add (or subtract when
//   built with BSA_SUB_EN). Operands are captured on an accepted start. The
//   block then feeds one bit pair per clock, LSB first, and keeps the carry
//   in a register between bits.
//
// Build option: BSA_SUB_EN adds the sub input, which selects A-B.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request, sampled only in IDLE
//   op_a    operand A, captured on accepted start
//   op_b    operand B, captured on accepted start
//   sub     (BSA_SUB_EN only) 1 = A-B, captured on accepted start
//   busy    high for the WIDTH RUN cycles of a transaction
//   done    one-cycle pulse; result/cout valid
//   result  sum or difference, held until the next completion
//   cout    carry out of the MSB (for sub: 1 = no borrow)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit pair through the cell per clock
// DONE  | done pulse, then back to IDLE

module bsa_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module bit_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef BSA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] result_nxt;
  logic [WIDTH:0]   result_cat;

  bsa_fa_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // Prepending the new sum bit and dropping the LSB also works for WIDTH=1.
  assign result_cat = {cell_s, result_sh};
  assign result_nxt = result_cat[WIDTH:1];

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
`ifdef BSA_SUB_EN
  // Two's complement subtract: invert B and preset the carry-in.
  assign b_load     = sub ? ~op_b : op_b;
  assign carry_load = sub;
`else
  assign b_load     = op_b;
  assign carry_load = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      result_sh <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            a_sh  <= op_a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          result_sh <= result_nxt;
          carry     <= cell_co;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= ST_DONE;
            result <= result_nxt;
            cout   <= cell_co;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
